sdp_ram_be: RTL and testbench

Parametrised simple-dual-port block RAM with byte-lane write enables, write-first collision forwarding, an optional output pipeline register and a read-valid flag. It is the general-purpose on-chip memory for the Cortex-M0 SoC: instruction/data RAM behind the bus bridges, plus any peripheral buffer that needs a block-RAM-mapped store. Port A is write-only and port B is read-only, both on one clock.

---
 rtl/soc_mem_pkg.sv | 25 ++
 rtl/sdp_ram_be_merge.sv | 28 ++
 rtl/sdp_ram_be.sv | 128 ++++++++++++
 tb/tb_sdp_ram_be.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_mem_pkg.sv
// Shared on-chip memory definitions: lane-count derivation, geometry
// sanity check and the output-register mode constants.
package soc_mem_pkg;

  // Output stage selection for port B.
  localparam int OUT_REG_OFF = 0;  // data straight from the merge stage
  localparam int OUT_REG_ON  = 1;  // extra pipeline register on port B

  typedef enum logic {
    OUT_MODE_COMB = 1'b0,
    OUT_MODE_PIPE = 1'b1
  } out_mode_e;

  // Number of byte-enable lanes in one word.
  function automatic int nb_of(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

  // A word must split into a whole number of non-empty lanes.
  function automatic bit lanes_ok(input int data_width, input int byte_width);
    return (byte_width > 0) && (data_width >= byte_width) &&
           ((data_width % byte_width) == 0);
  endfunction

endpackage

// File: rtl/sdp_ram_be_merge.sv
// Per-lane select between the old array word and the forwarded write data.
// A lane takes the forwarded byte only when the read collided with a write
// that enabled that lane, which gives write-first behaviour per lane.
module sdp_ram_be_merge
  import soc_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int NB         = 4
) (
  input  logic                  hit_i,
  input  logic [NB-1:0]         wea_i,
  input  logic [DATA_WIDTH-1:0] old_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  // Lane mux: forwarded byte for written lanes of a colliding read.
  always_comb begin
    data_o = old_i;
    for (int i = 0; i < NB; i++) begin
      if (hit_i && wea_i[i]) begin
        data_o[i*BYTE_WIDTH +: BYTE_WIDTH] = din_i[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

endmodule

// File: rtl/sdp_ram_be.sv
// Simple-dual-port block RAM with byte-lane writes on port A, read-only
// port B, write-first collision forwarding, optional output register and a
// read-valid flag aligned with the read data.
//
// Handshake: there is no back-pressure. A read is issued by enb=1 at a clka
// edge; doutb_valid=1 marks the cycle(s) where doutb carries that read's
// result (1 edge later, or 2 with OUT_REG=1). A write is issued by ena=1
// with at least one wea bit set and always completes at that edge.
module sdp_ram_be
  import soc_mem_pkg::*;
#(
  parameter int    ADDR_WIDTH = 12,
  parameter int    DATA_WIDTH = 32,
  parameter int    BYTE_WIDTH = 8,
  parameter int    OUT_REG    = OUT_REG_OFF,
  parameter string INIT_FILE  = ""
) (
  input  logic                                      clka,
  input  logic                                      rsta,
  input  logic                                      ena,
  input  logic [nb_of(DATA_WIDTH, BYTE_WIDTH)-1:0]  wea,
  input  logic [ADDR_WIDTH-1:0]                     addra,
  input  logic [DATA_WIDTH-1:0]                     dina,
  input  logic                                      enb,
  input  logic [ADDR_WIDTH-1:0]                     addrb,
  output logic [DATA_WIDTH-1:0]                     doutb,
  output logic                                      doutb_valid
);

  localparam int NB    = nb_of(DATA_WIDTH, BYTE_WIDTH);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Refuse to elaborate a word that does not split into whole lanes.
  if (!lanes_ok(DATA_WIDTH, BYTE_WIDTH)) begin : g_bad_geometry
    $error("sdp_ram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end

  // Old array data captured at the read edge (read-first), one slice per lane.
  logic [DATA_WIDTH-1:0] old_word;

  // A same-cycle write to the read address with any lane enabled.
  logic collide_d;
  assign collide_d = ena && enb && (addra == addrb) && (|wea);

  // Storage is split per lane so each lane has exactly one write process.
  for (genvar l = 0; l < NB; l++) begin : g_lane
    (* ram_style = "block" *) logic [BYTE_WIDTH-1:0] mem_lane [DEPTH];
    logic [BYTE_WIDTH-1:0] rd_lane_q;

    // Lane write; held off while reset is asserted, contents never cleared.
    always_ff @(posedge clka) begin
      if (ena && wea[l] && !rsta) begin
        mem_lane[addra] <= dina[l*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end

    // Lane read, returning the word as it was before this edge's write.
    always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
        rd_lane_q <= '0;
      end else if (enb) begin
        rd_lane_q <= mem_lane[addrb];
      end
    end

    assign old_word[l*BYTE_WIDTH +: BYTE_WIDTH] = rd_lane_q;
  end

  // Stage-1 forwarding state travelling alongside the array read.
  logic                  s1_valid_q;
  logic                  s1_hit_q;
  logic [DATA_WIDTH-1:0] s1_din_q;
  logic [NB-1:0]         s1_wea_q;

  // Stage-1 capture: valid follows enb every edge, payload holds when idle.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      s1_valid_q <= 1'b0;
      s1_hit_q   <= 1'b0;
      s1_din_q   <= '0;
      s1_wea_q   <= '0;
    end else begin
      s1_valid_q <= enb;
      if (enb) begin
        s1_hit_q <= collide_d;
        s1_din_q <= dina;
        s1_wea_q <= wea;
      end
    end
  end

  logic [DATA_WIDTH-1:0] merged_word;

  sdp_ram_be_merge #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH),
    .NB         (NB)
  ) u_merge (
    .hit_i  (s1_hit_q),
    .wea_i  (s1_wea_q),
    .old_i  (old_word),
    .din_i  (s1_din_q),
    .data_o (merged_word)
  );

  if (OUT_REG == OUT_REG_ON) begin : g_out_pipe
    logic [DATA_WIDTH-1:0] s2_data_q;
    logic                  s2_valid_q;

    // Output register advances every edge; idle stage 1 keeps data steady.
    always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
        s2_data_q  <= '0;
        s2_valid_q <= 1'b0;
      end else begin
        s2_data_q  <= merged_word;
        s2_valid_q <= s1_valid_q;
      end
    end

    assign doutb       = s2_data_q;
    assign doutb_valid = s2_valid_q;
  end else begin : g_out_comb
    assign doutb       = merged_word;
    assign doutb_valid = s1_valid_q;
  end

endmodule

// File: tb/tb_sdp_ram_be.sv
// Bench for sdp_ram_be: two 32-bit instances (no output register / output
// register) sharing stimulus, plus a 64-bit, 16-word instance.
module tb_sdp_ram_be;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [3:0]  wea;
  logic [11:0] addra;
  logic [31:0] dina;
  logic        enb;
  logic [11:0] addrb;
  logic [31:0] dout0, dout1;
  logic        v0, v1;

  logic        ena64;
  logic [7:0]  wea64;
  logic [3:0]  addra64;
  logic [63:0] dina64;
  logic        enb64;
  logic [3:0]  addrb64;
  logic [63:0] dout64;
  logic        v64;

  int total = 0;
  int bad   = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  sdp_ram_be #(.OUT_REG(0)) dut0 (
    .clka(clk), .rsta(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .enb(enb), .addrb(addrb), .doutb(dout0), .doutb_valid(v0)
  );

  sdp_ram_be #(.OUT_REG(1)) dut1 (
    .clka(clk), .rsta(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .enb(enb), .addrb(addrb), .doutb(dout1), .doutb_valid(v1)
  );

  sdp_ram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .BYTE_WIDTH(8), .OUT_REG(0)) dut64 (
    .clka(clk), .rsta(rst), .ena(ena64), .wea(wea64), .addra(addra64), .dina(dina64),
    .enb(enb64), .addrb(addrb64), .doutb(dout64), .doutb_valid(v64)
  );

  // ---------------- reference model ----------------
  // Memory contents as the spec defines them, plus the result history of
  // the last two edges (index 0 = newest). Reads are write-first per lane.
  logic [31:0] mem_m [64];
  logic [31:0] hist_d [2];
  logic        hist_v [2];
  logic [31:0] last_rd;

  task automatic model_reset();
    hist_d[0] = '0; hist_d[1] = '0;
    hist_v[0] = 1'b0; hist_v[1] = 1'b0;
    last_rd   = '0;
  endtask

  task automatic model_edge();
    logic [31:0] rd;
    if (rst) begin
      model_reset();
      return;
    end
    if (enb) begin
      rd = mem_m[addrb[5:0]];
      for (int i = 0; i < 4; i++)
        if (ena && wea[i] && (addra == addrb)) rd[i*8 +: 8] = dina[i*8 +: 8];
      last_rd = rd;
    end
    hist_d[1] = hist_d[0];
    hist_v[1] = hist_v[0];
    hist_d[0] = last_rd;
    hist_v[0] = enb;
    if (ena)
      for (int i = 0; i < 4; i++)
        if (wea[i]) mem_m[addra[5:0]][i*8 +: 8] = dina[i*8 +: 8];
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_dout0"}, {32'h0, dout0}, {32'h0, hist_d[0]});
    chk({tag, "_v0"}, {63'h0, v0}, {63'h0, hist_v[0]});
    chk({tag, "_dout1"}, {32'h0, dout1}, {32'h0, hist_d[1]});
    chk({tag, "_v1"}, {63'h0, v1}, {63'h0, hist_v[1]});
  endtask

  // ---------------- driver ----------------
  // One clock edge: model follows the same inputs, outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic e_a, input logic [3:0] w, input logic [11:0] aa,
                       input logic [31:0] d, input logic e_b, input logic [11:0] ab);
    ena = e_a; wea = w; addra = aa; dina = d; enb = e_b; addrb = ab;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        ena;
    logic [3:0]  wea;
    logic [11:0] addra;
    logic [31:0] dina;
    logic        enb;
    logic [11:0] addrb;
    logic [31:0] e0d;
    logic        e0v;
    logic [31:0] e1d;
    logic        e1v;
  } vec_t;

  vec_t tbl [13];
  logic [63:0] m64 [16];
  logic [63:0] exp64;

  initial begin
    // basic read, then three idle cycles of hold
    tbl[0]  = '{1'b0, 4'h0, 12'h000, 32'h0,        1'b1, 12'h010, 32'h1234_5678, 1'b1, 32'h0,         1'b0};
    tbl[1]  = '{1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 12'h010, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b1};
    tbl[2]  = '{1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 12'h010, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0};
    tbl[3]  = '{1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 12'h010, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0};
    // byte-lane write, read on the next cycle
    tbl[4]  = '{1'b1, 4'b0101, 12'h020, 32'h1122_3344, 1'b0, 12'h000, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0};
    tbl[5]  = '{1'b0, 4'h0, 12'h000, 32'h0,        1'b1, 12'h020, 32'hAA22_CC44, 1'b1, 32'h1234_5678, 1'b0};
    // collision, then a plain re-read
    tbl[6]  = '{1'b1, 4'b0001, 12'h030, 32'h0000_00EE, 1'b1, 12'h030, 32'hFFFF_FFEE, 1'b1, 32'hAA22_CC44, 1'b1};
    tbl[7]  = '{1'b0, 4'h0, 12'h000, 32'h0,        1'b1, 12'h030, 32'hFFFF_FFEE, 1'b1, 32'hFFFF_FFEE, 1'b1};
    // back-to-back reads of one address across a top-lane write
    tbl[8]  = '{1'b1, 4'b1000, 12'h030, 32'h1200_0000, 1'b1, 12'h030, 32'h12FF_FFEE, 1'b1, 32'hFFFF_FFEE, 1'b1};
    tbl[9]  = '{1'b0, 4'h0, 12'h000, 32'h0,        1'b1, 12'h030, 32'h12FF_FFEE, 1'b1, 32'h12FF_FFEE, 1'b1};
    // ena with no lanes, and lanes without ena: neither writes nor forwards
    tbl[10] = '{1'b1, 4'h0, 12'h030, 32'h0,        1'b1, 12'h030, 32'h12FF_FFEE, 1'b1, 32'h12FF_FFEE, 1'b1};
    tbl[11] = '{1'b0, 4'hF, 12'h030, 32'h0,        1'b1, 12'h030, 32'h12FF_FFEE, 1'b1, 32'h12FF_FFEE, 1'b1};
    tbl[12] = '{1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 12'h030, 32'h12FF_FFEE, 1'b0, 32'h12FF_FFEE, 1'b1};

    // ---------------- reset ----------------
    rst = 1'b1;
    drive(1'b0, 4'h0, 12'h0, 32'h0, 1'b0, 12'h0);
    ena64 = 1'b0; wea64 = '0; addra64 = '0; dina64 = '0; enb64 = 1'b0; addrb64 = '0;
    model_reset();
    tick();
    tick();
    chk("rst_dout0", {32'h0, dout0}, 64'h0);
    chk("rst_v0", {63'h0, v0}, 64'h0);
    chk("rst_dout1", {32'h0, dout1}, 64'h0);
    chk("rst_v1", {63'h0, v1}, 64'h0);
    chk("rst_dout64", dout64, 64'h0);
    chk("rst_v64", {63'h0, v64}, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- preload words 0..63 ----------------
    for (int a = 0; a < 64; a++) begin
      logic [31:0] w;
      w = $urandom;
      if (a == 'h10) w = 32'h1234_5678;
      if (a == 'h20) w = 32'hAABB_CCDD;
      if (a == 'h30) w = 32'hFFFF_FFFF;
      drive(1'b1, 4'hF, 12'(a), w, 1'b0, 12'h0);
      tick();
    end

    // ---------------- table ----------------
    for (int k = 0; k < 13; k++) begin
      drive(tbl[k].ena, tbl[k].wea, tbl[k].addra, tbl[k].dina, tbl[k].enb, tbl[k].addrb);
      tick();
      chk($sformatf("tbl%0d_dout0", k), {32'h0, dout0}, {32'h0, tbl[k].e0d});
      chk($sformatf("tbl%0d_v0", k), {63'h0, v0}, {63'h0, tbl[k].e0v});
      chk($sformatf("tbl%0d_dout1", k), {32'h0, dout1}, {32'h0, tbl[k].e1d});
      chk($sformatf("tbl%0d_v1", k), {63'h0, v1}, {63'h0, tbl[k].e1v});
    end

    // ---------------- async reset with a read in flight ----------------
    drive(1'b0, 4'h0, 12'h0, 32'h0, 1'b1, 12'h010);
    tick();
    check_model("inflight");
    enb = 1'b0;
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_dout0", {32'h0, dout0}, 64'h0);
    chk("async_v0", {63'h0, v0}, 64'h0);
    chk("async_dout1", {32'h0, dout1}, 64'h0);
    chk("async_v1", {63'h0, v1}, 64'h0);
    drive(1'b1, 4'hF, 12'h010, 32'hDEAD_BEEF, 1'b1, 12'h010);
    tick();
    chk("rst_hold_dout1", {32'h0, dout1}, 64'h0);
    chk("rst_hold_v1", {63'h0, v1}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 4'h0, 12'h0, 32'h0, 1'b0, 12'h010);
    tick();
    check_model("post_rst_idle");
    enb = 1'b1;
    tick();
    chk("post_rst_dout0", {32'h0, dout0}, {32'h0, 32'h1234_5678});
    chk("post_rst_v0", {63'h0, v0}, 64'h1);
    chk("post_rst_v1", {63'h0, v1}, 64'h0);
    enb = 1'b0;
    tick();
    chk("post_rst_dout1", {32'h0, dout1}, {32'h0, 32'h1234_5678});
    chk("post_rst_v1b", {63'h0, v1}, 64'h1);
    check_model("post_rst");

    // ---------------- randomized traffic vs model ----------------
    for (int n = 0; n < 500; n++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 12'($urandom_range(0, 7)),
            $urandom, ($urandom_range(0, 3) != 0), 12'($urandom_range(0, 7)));
      tick();
      check_model($sformatf("rnd%0d", n));
    end
    drive(1'b0, 4'h0, 12'h0, 32'h0, 1'b0, 12'h0);

    // ---------------- 64-bit, 16-word instance ----------------
    for (int a = 0; a < 16; a++) begin
      m64[a] = {$urandom, $urandom};
      ena64 = 1'b1; wea64 = 8'hFF; addra64 = 4'(a); dina64 = m64[a];
      tick();
    end
    ena64 = 1'b1; wea64 = 8'h80; addra64 = 4'd15; dina64 = 64'hAB00_0000_0000_0000;
    tick();
    ena64 = 1'b0; enb64 = 1'b1; addrb64 = 4'd15;
    tick();
    exp64 = {8'hAB, m64[15][55:0]};
    chk("w64_top_byte", dout64, exp64);
    chk("w64_v", {63'h0, v64}, 64'h1);
    addrb64 = 4'd0;
    tick();
    chk("w64_addr0", dout64, m64[0]);
    // collision on the low lane of word 3
    ena64 = 1'b1; wea64 = 8'h01; addra64 = 4'd3; dina64 = 64'h0000_0000_0000_00CD; addrb64 = 4'd3;
    tick();
    exp64 = {m64[3][63:8], 8'hCD};
    chk("w64_collide", dout64, exp64);
    ena64 = 1'b0; enb64 = 1'b0;
    tick();
    chk("w64_hold", dout64, exp64);
    chk("w64_hold_v", {63'h0, v64}, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
